// File: rtl/command_dispatcher_pkg.sv
// Shared types and constants for the command dispatcher.
//   cmd_type_e : command codes carried in cmd_type[3:0]
//   state_e    : sequencer states
//   FLAG_* / STAT_* : bit positions in flags_out / flags_in
//   HEATER_*   : heater select codes carried in cmd_t[1:0]
package cmd_dispatch_pkg;

  typedef enum logic [3:0] {
    CMD_NOP      = 4'd0,
    CMD_MOVE     = 4'd1,
    CMD_HOME     = 4'd2,
    CMD_SET_TEMP = 4'd3,
    CMD_DWELL    = 4'd4
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DWELL,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int FLAG_STROBE   = 0;
  localparam int FLAG_ABORT    = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ERROR    = 2;

  localparam logic [1:0] HEATER_E0  = 2'd0;
  localparam logic [1:0] HEATER_E1  = 2'd1;
  localparam logic [1:0] HEATER_BED = 2'd2;

endpackage

// File: rtl/command_dispatcher_if.sv
// Motion-executor handshake bundle.
//   mv_valid/mv_ready : request handshake (dispatcher -> executor)
//   mv_home           : 1 = home, 0 = linear move; valid with mv_valid
//   mv_x..mv_f        : move targets, stable while mv_valid is high
//   mv_done           : single-cycle completion pulse from the executor
//   mv_abort          : single-cycle abort pulse to the executor
interface command_dispatcher_if;
  logic        mv_valid;
  logic        mv_ready;
  logic        mv_home;
  logic [31:0] mv_x;
  logic [31:0] mv_y;
  logic [31:0] mv_z;
  logic [31:0] mv_e0;
  logic [31:0] mv_e1;
  logic [31:0] mv_f;
  logic        mv_done;
  logic        mv_abort;

  modport master (
    output mv_valid, mv_home, mv_x, mv_y, mv_z, mv_e0, mv_e1, mv_f, mv_abort,
    input  mv_ready, mv_done
  );

  modport slave (
    input  mv_valid, mv_home, mv_x, mv_y, mv_z, mv_e0, mv_e1, mv_f, mv_abort,
    output mv_ready, mv_done
  );
endinterface

// File: rtl/command_dispatcher_temp_clamp.sv
// Unsigned minimum of a requested temperature and its limit.
//   value  : requested setpoint
//   limit  : maximum allowed setpoint
//   result : min(value, limit)
module temp_clamp #(
  parameter int TEMP_W = 12
) (
  input  logic [TEMP_W-1:0] value,
  input  logic [TEMP_W-1:0] limit,
  output logic [TEMP_W-1:0] result
);
  assign result = (value > limit) ? limit : value;
endmodule

// File: rtl/command_dispatcher.sv
// Sequencer between the HPS command PIO registers and the printer executors.
// A rising edge of flags_out[0] in IDLE latches all cmd_* fields at once,
// then the command is either handed to the motion executor or run locally
// (heater setpoint with clamping, dwell, NOP). Status returns on flags_in.
//   clk_clk, reset_reset_n : clock, async active-low reset
//   cmd_*                  : command PIO fields from the HPS
//   flags_out              : bit0 strobe, bit1 abort (level)
//   flags_in               : bit0 busy, bit1 done, bit2 error, [7:4] last type
//   max_temp_*             : heater limits
//   tick_en                : 1 us enable pulse for dwell counting
//   mv                     : motion executor handshake (master side)
//   tgt_*                  : heater setpoints
module command_dispatcher
  import cmd_dispatch_pkg::*;
#(
  parameter int TEMP_W  = 12,
  parameter int DWELL_W = 32
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [31:0]          cmd_type,
  input  logic [31:0]          cmd_x,
  input  logic [31:0]          cmd_y,
  input  logic [31:0]          cmd_z,
  input  logic [31:0]          cmd_e0,
  input  logic [31:0]          cmd_e1,
  input  logic [31:0]          cmd_f,
  input  logic [31:0]          cmd_t,
  input  logic [31:0]          cmd_dt,
  input  logic [31:0]          flags_out,
  output logic [31:0]          flags_in,
  input  logic [TEMP_W-1:0]    max_temp_e0,
  input  logic [TEMP_W-1:0]    max_temp_e1,
  input  logic [TEMP_W-1:0]    max_temp_bed,
  input  logic                 tick_en,
  command_dispatcher_if.master mv,
  output logic [TEMP_W-1:0]    tgt_e0,
  output logic [TEMP_W-1:0]    tgt_e1,
  output logic [TEMP_W-1:0]    tgt_bed
);

  state_e               state, state_nxt;
  logic                 strb_q;
  logic                 strobe, abort, strobe_rise;
  logic                 abort_mv, set_temp_wr;
  logic                 busy_q, done_q, error_q;
  logic [3:0]           last_type;
  logic [DWELL_W-1:0]   dwell_cnt;

  // Latched command snapshot, written only in LATCH
  logic [3:0]           lat_type;
  logic [31:0]          lat_x, lat_y, lat_z, lat_e0, lat_e1, lat_f;
  logic [1:0]           lat_heater;
  logic [TEMP_W-1:0]    lat_temp;
  logic [DWELL_W-1:0]   lat_dt;

  logic [TEMP_W-1:0]    limit_sel, temp_clamped;

  // Only some bits of the wide PIO words carry information
  logic                 unused_bits;
  assign unused_bits = ^{cmd_type, cmd_t, cmd_f, cmd_dt, flags_out};

  assign strobe      = flags_out[FLAG_STROBE];
  assign abort       = flags_out[FLAG_ABORT];
  assign strobe_rise = strobe & ~strb_q;

  assign flags_in = {24'd0, last_type, 1'b0, error_q, done_q, busy_q};

  // State register and strobe history
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= S_IDLE;
      strb_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      strb_q <= strobe;
    end
  end

  // Next-state logic; abort takes priority over ready/done/tick
  always_comb begin
    state_nxt   = state;
    abort_mv    = 1'b0;
    set_temp_wr = 1'b0;
    case (state)
      S_IDLE:   if (strobe_rise) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (lat_type)
          CMD_NOP:            state_nxt = S_DONE;
          CMD_MOVE, CMD_HOME: state_nxt = S_ISSUE;
          CMD_SET_TEMP: begin
            if (lat_heater == 2'd3) begin
              state_nxt = S_ERROR;
            end else begin
              state_nxt   = S_DONE;
              set_temp_wr = 1'b1;
            end
          end
          CMD_DWELL: state_nxt = (lat_dt == '0) ? S_DONE : S_DWELL;
          default:   state_nxt = S_ERROR;
        endcase
      end
      S_ISSUE: begin
        if (abort) begin
          state_nxt = S_ERROR;
          abort_mv  = 1'b1;
        end else if (mv.mv_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_ERROR;
          abort_mv  = 1'b1;
        end else if (mv.mv_done) begin
          state_nxt = S_DONE;
        end
      end
      S_DWELL: begin
        if (abort) state_nxt = S_ERROR;
        else if (tick_en && dwell_cnt == DWELL_W'(1)) state_nxt = S_DONE;
      end
      S_DONE, S_ERROR: if (!strobe) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Limit selection for the heater addressed by the latched command
  always_comb begin
    limit_sel = max_temp_e0;
    case (lat_heater)
      HEATER_E1:  limit_sel = max_temp_e1;
      HEATER_BED: limit_sel = max_temp_bed;
      default:    limit_sel = max_temp_e0;
    endcase
  end

  temp_clamp #(.TEMP_W(TEMP_W)) u_clamp (
    .value  (lat_temp),
    .limit  (limit_sel),
    .result (temp_clamped)
  );

  // Command snapshot
  always_ff @(posedge clk_clk) begin
    if (state == S_LATCH) begin
      lat_type   <= cmd_type[3:0];
      lat_x      <= cmd_x;
      lat_y      <= cmd_y;
      lat_z      <= cmd_z;
      lat_e0     <= cmd_e0;
      lat_e1     <= cmd_e1;
      lat_f      <= cmd_f;
      lat_heater <= cmd_t[1:0];
      lat_temp   <= cmd_f[TEMP_W-1:0];
      lat_dt     <= cmd_dt[DWELL_W-1:0];
    end
  end

  // Registered outputs, derived from the next state so status and mv_valid
  // change on the same edge as the state itself
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      last_type   <= 4'd0;
      dwell_cnt   <= '0;
      mv.mv_valid <= 1'b0;
      mv.mv_abort <= 1'b0;
      mv.mv_home  <= 1'b0;
      mv.mv_x     <= '0;
      mv.mv_y     <= '0;
      mv.mv_z     <= '0;
      mv.mv_e0    <= '0;
      mv.mv_e1    <= '0;
      mv.mv_f     <= '0;
      tgt_e0      <= '0;
      tgt_e1      <= '0;
      tgt_bed     <= '0;
    end else begin
      busy_q      <= state_nxt inside {S_LATCH, S_DECODE, S_ISSUE, S_WAIT, S_DWELL};
      done_q      <= (state_nxt == S_DONE);
      error_q     <= (state_nxt == S_ERROR);
      mv.mv_valid <= (state_nxt == S_ISSUE);
      mv.mv_abort <= abort_mv;
      if (state == S_LATCH) last_type <= cmd_type[3:0];
      if (state == S_DECODE) begin
        dwell_cnt <= lat_dt;
        if (lat_type == CMD_MOVE || lat_type == CMD_HOME) begin
          mv.mv_home <= (lat_type == CMD_HOME);
          mv.mv_x    <= lat_x;
          mv.mv_y    <= lat_y;
          mv.mv_z    <= lat_z;
          mv.mv_e0   <= lat_e0;
          mv.mv_e1   <= lat_e1;
          mv.mv_f    <= lat_f;
        end
      end
      if (set_temp_wr) begin
        case (lat_heater)
          HEATER_E0:  tgt_e0  <= temp_clamped;
          HEATER_E1:  tgt_e1  <= temp_clamped;
          HEATER_BED: tgt_bed <= temp_clamped;
          default:    tgt_e0  <= tgt_e0;
        endcase
      end
      if (state == S_DWELL && tick_en) dwell_cnt <= dwell_cnt - DWELL_W'(1);
    end
  end

endmodule

// File: tb/tb_command_dispatcher.sv
module tb_command_dispatcher;

  localparam int TEMP_W  = 12;
  localparam int DWELL_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       cmd_type, cmd_x, cmd_y, cmd_z, cmd_e0, cmd_e1, cmd_f, cmd_t, cmd_dt;
  logic [31:0]       flags_out;
  logic [31:0]       flags_in;
  logic [TEMP_W-1:0] max_e0, max_e1, max_bed;
  logic              tick_en;
  logic [TEMP_W-1:0] tgt_e0, tgt_e1, tgt_bed;

  command_dispatcher_if mv_bus();

  command_dispatcher #(.TEMP_W(TEMP_W), .DWELL_W(DWELL_W)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .cmd_type      (cmd_type),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .cmd_z         (cmd_z),
    .cmd_e0        (cmd_e0),
    .cmd_e1        (cmd_e1),
    .cmd_f         (cmd_f),
    .cmd_t         (cmd_t),
    .cmd_dt        (cmd_dt),
    .flags_out     (flags_out),
    .flags_in      (flags_in),
    .max_temp_e0   (max_e0),
    .max_temp_e1   (max_e1),
    .max_temp_bed  (max_bed),
    .tick_en       (tick_en),
    .mv            (mv_bus),
    .tgt_e0        (tgt_e0),
    .tgt_e1        (tgt_e1),
    .tgt_bed       (tgt_bed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        home;
    logic [31:0] x, y, z, e0, e1, f;
  } move_t;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [7:0]        exp_status_q[$];
  move_t             move_q[$];
  logic [TEMP_W-1:0] exp_e0 = '0, exp_e1 = '0, exp_bed = '0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a command, strobe it, and record what the bench expects from it
  task automatic start_cmd(input logic [31:0] typ, x, y, z, e0, e1, f, t, dt,
                           input bit abort_exp);
    logic [2:0]        st;
    logic [TEMP_W-1:0] v, lim, clamped;
    cmd_type = typ; cmd_x = x; cmd_y = y; cmd_z = z;
    cmd_e0 = e0; cmd_e1 = e1; cmd_f = f; cmd_t = t; cmd_dt = dt;
    flags_out[0] = 1'b1;
    st = 3'b010;
    v  = f[TEMP_W-1:0];
    case (typ[3:0])
      4'd0, 4'd1, 4'd2, 4'd4: st = 3'b010;
      4'd3: begin
        if (t[1:0] == 2'd3) begin
          st = 3'b100;
        end else begin
          lim     = (t[1:0] == 2'd0) ? max_e0 : (t[1:0] == 2'd1) ? max_e1 : max_bed;
          clamped = (v > lim) ? lim : v;
          if (t[1:0] == 2'd0) exp_e0 = clamped;
          else if (t[1:0] == 2'd1) exp_e1 = clamped;
          else exp_bed = clamped;
        end
      end
      default: st = 3'b100;
    endcase
    if (abort_exp) st = 3'b100;
    exp_status_q.push_back({typ[3:0], 1'b0, st});
    if (typ[3:0] == 4'd1 || typ[3:0] == 4'd2)
      move_q.push_back('{home: (typ[3:0] == 4'd2), x: x, y: y, z: z, e0: e0, e1: e1, f: f});
    step(1);
    check("busy_n1", 64'(flags_in[2:0]), 64'(3'b001));
  endtask

  task automatic check_move(input string tag);
    move_t m;
    n_checks++;
    assert (move_q.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb: observed empty move queue expected an entry", tag);
    end
    if (move_q.size() != 0) begin
      m = move_q.pop_front();
      check({tag, "_valid"}, 64'(mv_bus.mv_valid), 64'(1));
      check({tag, "_home"},  64'(mv_bus.mv_home),  64'(m.home));
      check({tag, "_x"},     64'(mv_bus.mv_x),     64'(m.x));
      check({tag, "_y"},     64'(mv_bus.mv_y),     64'(m.y));
      check({tag, "_f"},     64'(mv_bus.mv_f),     64'(m.f));
    end
  endtask

  // Wait (bounded) for done/error, compare status and setpoints, release strobe
  task automatic finish_cmd(input string tag);
    int         waited;
    logic [7:0] exp;
    waited = 0;
    while (flags_in[2:1] == 2'b00 && waited < 300) begin
      step(1);
      waited++;
    end
    n_checks++;
    assert (exp_status_q.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb: observed empty status queue expected an entry", tag);
    end
    if (exp_status_q.size() != 0) begin
      exp = exp_status_q.pop_front();
      check({tag, "_status"}, 64'(flags_in[7:0]), 64'(exp));
    end
    check({tag, "_tgt_e0"},  64'(tgt_e0),  64'(exp_e0));
    check({tag, "_tgt_e1"},  64'(tgt_e1),  64'(exp_e1));
    check({tag, "_tgt_bed"}, 64'(tgt_bed), 64'(exp_bed));
    flags_out[0] = 1'b0;
    step(1);
    check({tag, "_release"}, 64'(flags_in[2:0]), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_type = '0; cmd_x = '0; cmd_y = '0; cmd_z = '0; cmd_e0 = '0;
    cmd_e1 = '0; cmd_f = '0; cmd_t = '0; cmd_dt = '0; flags_out = '0;
    max_e0 = 12'd260; max_e1 = 12'd250; max_bed = 12'd110;
    tick_en = 1'b0;
    mv_bus.mv_ready = 1'b0;
    mv_bus.mv_done  = 1'b0;
    step(2);
    check("rst_flags",    64'(flags_in),        64'(0));
    check("rst_mv_valid", 64'(mv_bus.mv_valid), 64'(0));
    check("rst_mv_abort", 64'(mv_bus.mv_abort), 64'(0));
    check("rst_mv_x",     64'(mv_bus.mv_x),     64'(0));
    check("rst_tgt_bed",  64'(tgt_bed),         64'(0));
    rst_n = 1'b1;
    step(2);

    // MOVE with delayed ready and late completion
    start_cmd(32'd1, 32'd1000, 32'd2000, 32'd300, 32'd40, 32'd50, 32'd6000, 32'd0, 32'd0, 1'b0);
    step(1);
    check("move_valid_n2", 64'(mv_bus.mv_valid), 64'(0));
    step(1);
    check_move("move_n3");
    step(1);
    check("move_valid_hold", 64'(mv_bus.mv_valid), 64'(1));
    check("move_x_hold",     64'(mv_bus.mv_x),     64'(1000));
    step(1);
    mv_bus.mv_ready = 1'b1;
    step(1);
    mv_bus.mv_ready = 1'b0;
    check("move_valid_drop", 64'(mv_bus.mv_valid), 64'(0));
    step(9);
    check("move_wait_busy", 64'(flags_in[2:0]), 64'(3'b001));
    mv_bus.mv_done = 1'b1;
    step(1);
    mv_bus.mv_done = 1'b0;
    check("move_done_m1", 64'(flags_in[2:0]), 64'(3'b010));
    finish_cmd("move");

    // SET_TEMP clamped to the bed limit, then an in-range extruder value
    start_cmd(32'd3, 0, 0, 0, 0, 0, 32'd300, 32'd2, 0, 1'b0);
    step(1);
    check("temp_bed_n2", 64'(flags_in[2:0]), 64'(3'b001));
    step(1);
    check("temp_bed_done_n3", 64'(flags_in[2:0]), 64'(3'b010));
    check("temp_bed_tgt_n3",  64'(tgt_bed),       64'(110));
    finish_cmd("temp_bed");
    start_cmd(32'd3, 0, 0, 0, 0, 0, 32'd200, 32'd0, 0, 1'b0);
    step(2);
    check("temp_e0_tgt_n3", 64'(tgt_e0), 64'(200));
    finish_cmd("temp_e0");

    // DWELL of 5 ticks, one tick every 3 cycles
    start_cmd(32'd4, 0, 0, 0, 0, 0, 0, 0, 32'd5, 1'b0);
    step(2);
    for (int k = 1; k <= 5; k++) begin
      step(2);
      tick_en = 1'b1;
      step(1);
      tick_en = 1'b0;
      if (k == 4) check("dwell_after_tick4", 64'(flags_in[2:0]), 64'(3'b001));
      if (k == 5) check("dwell_after_tick5", 64'(flags_in[2:0]), 64'(3'b010));
    end
    finish_cmd("dwell5");
    start_cmd(32'd4, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0);
    step(2);
    check("dwell0_done_n3", 64'(flags_in[2:0]), 64'(3'b010));
    finish_cmd("dwell0");

    // Illegal type and illegal heater select
    start_cmd(32'd9, 32'd5, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    step(1);
    check("illegal_valid_n2", 64'(mv_bus.mv_valid), 64'(0));
    step(1);
    check("illegal_err_n3",   64'(flags_in[2:0]),   64'(3'b100));
    check("illegal_valid_n3", 64'(mv_bus.mv_valid), 64'(0));
    finish_cmd("illegal");
    start_cmd(32'd3, 0, 0, 0, 0, 0, 32'd50, 32'd3, 0, 1'b0);
    step(2);
    check("heater3_err_n3", 64'(flags_in[2:0]), 64'(3'b100));
    finish_cmd("heater3");

    // HOME aborted in WAIT with a simultaneous mv_done
    start_cmd(32'd2, 32'd7, 32'd8, 32'd9, 0, 0, 32'd100, 0, 0, 1'b1);
    step(2);
    check_move("home_n3");
    mv_bus.mv_ready = 1'b1;
    step(1);
    mv_bus.mv_ready = 1'b0;
    step(2);
    flags_out[1] = 1'b1;
    mv_bus.mv_done = 1'b1;
    step(1);
    mv_bus.mv_done = 1'b0;
    check("abort_pulse", 64'(mv_bus.mv_abort), 64'(1));
    check("abort_err",   64'(flags_in[2:0]),   64'(3'b100));
    step(1);
    check("abort_pulse_end", 64'(mv_bus.mv_abort), 64'(0));
    flags_out[1] = 1'b0;
    finish_cmd("abort");

    // Strobe re-edge while busy must not restart or relatch
    start_cmd(32'd4, 0, 0, 0, 0, 0, 0, 0, 32'd3, 1'b0);
    step(2);
    flags_out[0] = 1'b0;
    cmd_type = 32'd0;
    step(1);
    flags_out[0] = 1'b1;
    step(1);
    check("reedge_busy", 64'(flags_in[7:0]), 64'(8'h41));
    tick_en = 1'b1;
    step(3);
    tick_en = 1'b0;
    finish_cmd("reedge");
    step(2);
    check("reedge_idle", 64'(flags_in[2:0]), 64'(0));

    // Async reset in the middle of a long dwell
    start_cmd(32'd4, 0, 0, 0, 0, 0, 0, 0, 32'd100, 1'b0);
    step(2);
    tick_en = 1'b1;
    step(3);
    tick_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_flags",    64'(flags_in),        64'(0));
    check("arst_mv_x",     64'(mv_bus.mv_x),     64'(0));
    check("arst_mv_home",  64'(mv_bus.mv_home),  64'(0));
    check("arst_mv_abort", 64'(mv_bus.mv_abort), 64'(0));
    check("arst_tgt_e0",   64'(tgt_e0),          64'(0));
    check("arst_tgt_bed",  64'(tgt_bed),         64'(0));
    exp_status_q.delete();
    exp_e0 = '0; exp_e1 = '0; exp_bed = '0;
    flags_out[0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    check("arst_idle",       64'(flags_in),        64'(0));
    check("arst_no_abort",   64'(mv_bus.mv_abort), 64'(0));
    start_cmd(32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    step(2);
    check("nop_done_n3", 64'(flags_in[2:0]), 64'(3'b010));
    finish_cmd("nop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/command_dispatcher.md
# command_dispatcher

Sequencer between the HPS-written command PIO registers and the FPGA-side printer executors (motion planner, heater controllers). It detects a new command through the flags_out/flags_in handshake and latches all command fields atomically. It then dispatches the command to the motion executor over a valid/ready/done handshake, or executes it locally (temperature set with clamping, dwell, NOP), and reports busy/done/error status back to the HPS.

## Interface
Parameters:
- TEMP_W, 12, heater temperature/limit width
- DWELL_W, 32, dwell counter width

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  async active-low reset
- cmd_type, cmd_x, cmd_y, cmd_z, cmd_e0, cmd_e1, cmd_f, cmd_t, cmd_dt  in  32 each  command PIO outputs
- flags_out  in  32  HPS→FPGA flags; bit0 cmd_strobe, bit1 abort
- flags_in  out  32  FPGA→HPS status; bit0 busy, bit1 done, bit2 error, bits[7:4] last cmd_type[3:0], rest 0
- max_temp_e0, max_temp_e1, max_temp_bed  in  TEMP_W  temperature limits
- tick_en  in  1  1 µs single-cycle enable pulse
- mv_valid  out  1  move/home request to motion executor
- mv_ready  in  1  executor accepts request
- mv_home  out  1  1 = home, 0 = linear move (valid with mv_valid)
- mv_x, mv_y, mv_z, mv_e0, mv_e1, mv_f  out  32 each  latched targets
- mv_done  in  1  single-cycle completion pulse from executor
- mv_abort  out  1  single-cycle abort pulse
- tgt_e0, tgt_e1, tgt_bed  out  TEMP_W  heater setpoints

## Operation
- Command types in cmd_type[3:0]: 0 NOP, 1 MOVE, 2 HOME, 3 SET_TEMP, 4 DWELL; any other value is illegal.
- Rising edge of flags_out[0] (detected against its registered copy) in IDLE starts a command. Edges outside IDLE are ignored.
- States:
  - IDLE: wait for a strobe rising edge.
  - LATCH: capture all cmd_* fields into internal registers; go to DECODE.
  - DECODE:
    - NOP → DONE.
    - MOVE/HOME → ISSUE.
    - SET_TEMP → write setpoint, then DONE.
    - DWELL with dt = 0 → DONE; dt ≠ 0 → DWELL.
    - Illegal type → ERROR.
  - ISSUE: hold mv_valid until mv_ready is sampled high; then go to WAIT.
  - WAIT: on mv_done → DONE.
  - DWELL: decrement the counter on each tick_en; reaching 0 → DONE.
  - DONE / ERROR: hold until flags_out[0] = 0, then return to IDLE.
- SET_TEMP: cmd_t[1:0] selects the heater (0 e0, 1 e1, 2 bed; 3 → ERROR). Value is cmd_f[TEMP_W-1:0], clamped to the matching max_temp (unsigned compare). Setpoints hold until the next SET_TEMP or reset.
- Status bits:
  - busy = 1 in LATCH through WAIT/DWELL.
  - done = 1 in DONE; error = 1 in ERROR.
  - flags_in[7:4] is updated in LATCH.
- Abort (flags_out[1] = 1, level):
  - From ISSUE, WAIT or DWELL: one-cycle mv_abort pulse (ISSUE/WAIT only), drop mv_valid, go to ERROR.
  - In IDLE, DONE or ERROR: no effect.
- mv_done outside WAIT is ignored. mv_done and abort in the same cycle: abort wins.

## Timing
- Reset values: all flags_in bits 0, mv_valid 0, mv_abort 0, mv_home 0, mv_* 0, tgt_* 0, state IDLE, strobe history 0.
- Strobe edge at cycle n → LATCH at n+1 → DECODE at n+2 → busy visible at n+1.
- mv_valid asserts at n+3; all mv_* fields are stable while mv_valid = 1.
- NOP: done = 1 at n+3.
- SET_TEMP: tgt_* updates and done = 1 at n+3.
- DWELL dt = N: done 1 cycle after the N-th tick_en counted in DWELL.
- mv_done at cycle m in WAIT → done = 1 at m+1.
- Strobe low in DONE/ERROR at cycle k → IDLE at k+1, flags_in[2:0] = 0 at k+1. A new edge is accepted from k+2.
- All outputs registered; no combinational input→output path.
- Reset mid-command: immediate return to IDLE; no mv_abort pulse is issued.

## Structure
- Package cmd_dispatch_pkg: cmd_type enum (NOP..DWELL), state enum, flag bit index constants, heater index constants.
- Sub-module temp_clamp (combinational min of value and limit, TEMP_W wide), instantiated once and muxed by heater index.

## Test plan
- MOVE: cmd_type=1, x=1000, strobe 0→1; ready high 2 cycles after valid; mv_done 10 cycles later → mv_x=1000, mv_home=0, busy then done=1, flags_in[7:4]=1. Strobe low → flags_in[2:0]=0.
- SET_TEMP: t=2, f=300, max_temp_bed=110 → tgt_bed=110, done at n+3. Then t=0, f=200, max_temp_e0=260 → tgt_e0=200.
- DWELL: dt=5, tick_en every 3 cycles → done exactly 1 cycle after the 5th tick. dt=0 → done at n+3.
- Illegal: cmd_type=9 → error=1, no mv_valid. Also t=3 SET_TEMP → error=1, tgt_* unchanged.
- Abort in WAIT: abort=1 while waiting → one mv_abort pulse, error=1. Simultaneous mv_done → still error.
- Strobe re-edge while busy is ignored. Async reset asserted mid-DWELL → all outputs 0, state IDLE.
